// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch unit feeding the LemonPC execute datapath.
//
// Generates sequential fetch addresses starting at PC_INIT. It keeps at most
// one read request outstanding to instruction memory and buffers the returned
// {pc, inst} pairs in a DEPTH-entry FIFO. The core drains that FIFO over a
// valid/ready handshake. A redirect flushes the buffered stream, discards any
// in-flight response and restarts fetch at redirect_pc.
//
// Parameters:
//   PC_INIT  first fetch address after reset
//   DEPTH    FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready       fetch request handshake
//   req_addr                  fetch address (the enclosing 8-byte word is read)
//   resp_valid/resp_data      read data for the accepted request
//   out_valid/out_ready       instruction handshake towards the core
//   out_pc/out_inst           PC and 32-bit instruction being offered
//   redirect_valid            one-cycle flush-and-restart pulse
//   redirect_pc               restart address
//
// Build option:
//   IFU_BYPASS_EN  when defined, a response that arrives while the FIFO is
//                  empty is presented on the out port in the same cycle. If the
//                  core takes it, it never enters the FIFO.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [63:0] PC_INIT = 64'h8000_0000,
  parameter int          DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state_r;
  logic [63:0]      fetch_pc_r;    // next address to be requested
  logic [63:0]      req_pc_r;      // address of the in-flight request
  logic [63:0]      req_addr_r;    // address currently presented on req_addr
  logic             req_valid_r;
  logic             drop_mark_r;   // presented request was overtaken by a redirect
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [63:0]      pc_mem_r   [DEPTH];
  logic [31:0]      inst_mem_r [DEPTH];

  logic [PTR_W-1:0] count_s;
  logic [PTR_W-1:0] count_nxt_s;
  logic             empty_s;
  logic             room_s;
  logic             req_fire_s;
  logic             resp_take_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      resp_inst_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
`ifdef IFU_BYPASS_EN
  logic             bypass_s;
`endif

  assign req_valid = req_valid_r;
  assign req_addr  = req_addr_r;

  // Handshake decode, FIFO occupancy and the out-port view
  always_comb begin
    count_s     = wr_ptr_r - rd_ptr_r;
    empty_s     = (count_s == {PTR_W{1'b0}});
    rd_idx_s    = rd_ptr_r[IDX_W-1:0];
    wr_idx_s    = wr_ptr_r[IDX_W-1:0];
    req_fire_s  = req_valid_r && req_ready;
    // A response landing in a redirect cycle is stale and must not be kept.
    resp_take_s = (state_r == WAIT) && resp_valid && !redirect_valid;
    resp_inst_s = req_pc_r[2] ? resp_data[63:32] : resp_data[31:0];
    pop_s       = out_ready && !empty_s;
`ifdef IFU_BYPASS_EN
    bypass_s    = resp_take_s && empty_s;
    push_s      = resp_take_s && !(bypass_s && out_ready);
    out_valid   = !empty_s || bypass_s;
    out_pc      = bypass_s ? req_pc_r    : pc_mem_r[rd_idx_s];
    out_inst    = bypass_s ? resp_inst_s : inst_mem_r[rd_idx_s];
`else
    push_s      = resp_take_s;
    out_valid   = !empty_s;
    out_pc      = pc_mem_r[rd_idx_s];
    out_inst    = inst_mem_r[rd_idx_s];
`endif
    if (redirect_valid) begin
      count_nxt_s = {PTR_W{1'b0}};
    end else begin
      count_nxt_s = count_s + {{(PTR_W-1){1'b0}}, push_s} - {{(PTR_W-1){1'b0}}, pop_s};
    end
    // A new request may only go out when its response is sure of a slot.
    room_s = (count_nxt_s < DEPTH_P);
  end

  // FIFO storage and pointers; a redirect empties it by catching rd up to wr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= 64'd0;
        inst_mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        pc_mem_r[wr_idx_s]   <= req_pc_r;
        inst_mem_r[wr_idx_s] <= resp_inst_s;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (redirect_valid) begin
        rd_ptr_r <= wr_ptr_r;
      end else if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Fetch FSM: request issue, response wait and stale-response drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= REQ;
      fetch_pc_r  <= PC_INIT;
      req_pc_r    <= 64'd0;
      req_addr_r  <= PC_INIT;
      req_valid_r <= 1'b0;
      drop_mark_r <= 1'b0;
    end else begin
      case (state_r)
        REQ: begin
          if (req_fire_s) begin
            req_valid_r <= 1'b0;
            drop_mark_r <= 1'b0;
            req_pc_r    <= req_addr_r;
            if (redirect_valid) begin
              state_r    <= DROP;
              fetch_pc_r <= redirect_pc;
              req_addr_r <= redirect_pc;
            end else if (drop_mark_r) begin
              // fetch_pc already holds the redirect target; it is not yet fetched
              state_r    <= DROP;
              req_addr_r <= fetch_pc_r;
            end else begin
              state_r    <= WAIT;
              fetch_pc_r <= fetch_pc_r + 64'd4;
              req_addr_r <= fetch_pc_r + 64'd4;
            end
          end else begin
            req_valid_r <= room_s;
            if (redirect_valid) begin
              fetch_pc_r <= redirect_pc;
              if (req_valid_r) begin
                // the presented request must stay stable until it is accepted
                drop_mark_r <= 1'b1;
              end else begin
                req_addr_r <= redirect_pc;
              end
            end
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            req_addr_r <= redirect_pc;
          end
          if (resp_valid) begin
            state_r     <= REQ;
            req_valid_r <= room_s;
          end else if (redirect_valid) begin
            state_r <= DROP;
          end
        end
        DROP: begin
          if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            req_addr_r <= redirect_pc;
          end
          if (resp_valid) begin
            state_r     <= REQ;
            req_valid_r <= room_s;
          end
        end
        default: begin
          state_r     <= REQ;
          req_valid_r <= 1'b0;
          drop_mark_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit upstream of the LemonPC execute datapath. It generates sequential fetch addresses starting at `PC_INIT`, issues one-outstanding read requests to instruction memory over a valid/ready handshake, and buffers returned `{pc, inst}` pairs in a small FIFO. The core consumes these pairs over a second valid/ready handshake. A redirect port from the execute stage (branch/jump `dnpc`) flushes the buffered stream and restarts fetch at the new address.

## Interface
- `PC_INIT`, `64'h8000_0000`, first fetch address after reset
- `DEPTH`, `2`, FIFO entries (power of two, ≥ 2)
- `clk  in  1  clock, rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `req_valid  out  1  fetch request valid`
- `req_ready  in  1  memory accepts request`
- `req_addr  out  64  fetch address; 8-byte-aligned word holds the instruction`
- `resp_valid  in  1  read data valid for the accepted request`
- `resp_data  in  64  read word; instruction = `addr[2]` ? [63:32] : [31:0]`
- `out_valid  out  1  instruction available`
- `out_ready  in  1  core consumes instruction`
- `out_pc  out  64  PC of `out_inst``
- `out_inst  out  32  instruction`
- `redirect_valid  in  1  flush and restart, one-cycle pulse`
- `redirect_pc  in  64  restart address`

## Operation
- Registers: `fetch_pc`, `req_pc` (address of the in-flight request), FIFO with `rd_ptr`/`wr_ptr` of log2(DEPTH)+1 bits, `state`.
- States: `REQ` (drive request), `WAIT` (one request outstanding), `DROP` (outstanding response must be discarded).
- `REQ`: `req_valid=1` only when `count + 0 < DEPTH`; otherwise stay in `REQ` with `req_valid=0`. On `req_valid&&req_ready`: `req_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4`, go to `WAIT`.
- Once asserted, `req_valid` and `req_addr` hold stable until accepted, including across redirects.
- `WAIT`: on `resp_valid`, push `{req_pc, selected half}` to the FIFO, go to `REQ`. The slot is guaranteed because the request was only issued with a free slot.
- `DROP`: on `resp_valid`, discard the data and go to `REQ`.
- Redirect, taking priority over everything:
  - The FIFO is flushed (`rd_ptr<=wr_ptr`) and `fetch_pc<=redirect_pc`.
  - In `WAIT`, or in `REQ` with the request accepted the same cycle, next state is `DROP`.
  - In `REQ` with `req_valid&&!req_ready`, the pending request is still completed and dropped: it is marked and, once accepted, goes to `DROP`.
  - A response arriving in the redirect cycle is discarded.
  - An out handshake in the redirect cycle completes normally. The core is responsible for ignoring it.
- `fetch_pc` wraps modulo 2^64.
- `redirect_pc[1:0]` is assumed zero by the core. The unit fetches the enclosing word and does not check alignment.

## Timing
- Reset values: `req_valid=0`, `req_addr=PC_INIT`, `out_valid=0`, `out_pc=0`, `out_inst=0`, FIFO empty, `state=REQ`, `fetch_pc=PC_INIT`.
- First `req_valid=1` occurs in the first cycle after `rst` deasserts.
- Response latency from memory is ≥ 1 cycle after acceptance. `resp_valid` is asserted only while a request is outstanding.
- Without bypass, `out_valid` rises the cycle after `resp_valid`.
- Throughput with 1-cycle memory: one instruction per 2 cycles.
- A FIFO that is full and not draining stalls requests. A pop and a push in the same cycle are both allowed.
- `rst` asserted mid-transaction returns everything to reset values immediately. Any later stray `resp_valid` is ignored in `REQ`.

## Configuration
- `IFU_BYPASS_EN` defined: when the FIFO is empty, the state is `WAIT` and `resp_valid=1`, the response drives `out_valid/out_pc/out_inst` combinationally in the same cycle. If `out_ready=1`, it is consumed without being written to the FIFO; otherwise it is pushed. Redirect still suppresses the bypass.
- Not defined: all responses pass through the FIFO, adding one cycle of latency.

## Test plan
- **Reset then free-run:** 1-cycle memory, `out_ready=1`. Expect requests at `0x80000000, 0x80000004, …`; `out_pc` follows the same sequence; `out_inst` is the upper half when `pc[2]=1`.
- **Backpressure:** `out_ready=0` for 10 cycles. Exactly `DEPTH` entries are buffered and `req_valid` drops to 0. On releasing `out_ready`, entries drain in order with none lost.
- **Redirect while WAIT:** redirect to `0x80000100`. The in-flight response is dropped, `out_valid=0`, and the next request is to `0x80000100`.
- **Redirect while `req_valid && !req_ready`:** `req_addr` holds its old value until accepted, the response is dropped, and the next request is to `redirect_pc`.
- **Async reset mid-WAIT:** `rst` pulses between clock edges. `req_valid/out_valid` drop immediately; a following `resp_valid` is ignored; fetch restarts at `PC_INIT`.
- **`IFU_BYPASS_EN`:** with the FIFO empty, `out_ready=1` and `resp_valid` at cycle N, `out_valid=1` at cycle N and the FIFO count stays 0.
